dev_timer: RTL and testbench

Memory-mapped countdown timer on the CPU data bus: the responder for the `m_data_addr` / `m_data_wdata` / `m_data_byteen` / `m_data_rdata` initiator port.

- Decodes a 16-byte window, holds CTRL/PRESET/COUNT, and runs a four-state countdown FSM.
- Drives one interrupt line that the system top wires into one bit of the CPU's `HWInt[5:0]`.
- The system top muxes its `rdata` onto `m_data_rdata` when the address falls in its window.

---
 rtl/dev_timer_pkg.sv | 39 +++
 rtl/dev_timer.sv | 110 +++++++++++
 tb/tb_dev_timer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dev_timer_pkg.sv
// ============================================================================
// dev_timer_pkg : register offsets, CTRL bit positions, FSM states, lane merge
// Revision 1.0
// ============================================================================
`default_nettype none

package dev_timer_pkg;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Replace each byte lane whose enable is set, keep the others.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dev_timer.sv
// ============================================================================
// dev_timer : memory-mapped countdown timer (CTRL/PRESET/COUNT) with IRQ line
// Revision 1.0
// ============================================================================
`default_nettype none

module dev_timer
  import dev_timer_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [3:0]  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_pend_q;
  state_e      state_q;

  logic        sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic [31:0] ctrl_merged;
  logic [3:0]  ctrl_d;
  logic [31:0] preset_d;
  logic        en;
  logic        mode_nz;
  logic        unused_addr_lsb;

  assign sel       = (addr[31:4] == BASE[31:4]);
  assign wr_ctrl   = sel && (byteen != 4'b0000) && (addr[3:2] == TC_CTRL);
  assign wr_preset = sel && (byteen != 4'b0000) && (addr[3:2] == TC_PRESET);

  assign ctrl_merged = lane_merge({28'h0, ctrl_q}, wdata, byteen);
  assign ctrl_d      = ctrl_merged[3:0];
  assign preset_d    = lane_merge(preset_q, wdata, byteen);

  assign en      = ctrl_q[CTRL_EN];
  assign mode_nz = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] != 2'b00);

  assign unused_addr_lsb = ^addr[1:0];

  always_comb begin
    rdata = 32'h0;
    if (sel) begin
      case (addr[3:2])
        TC_CTRL:   rdata = {28'h0, ctrl_q};
        TC_PRESET: rdata = preset_q;
        TC_COUNT:  rdata = count_q;
        default:   rdata = 32'h0;
      endcase
    end
  end

  assign irq = ctrl_q[CTRL_IM] & irq_pend_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= 4'h0;
      preset_q   <= 32'h0;
      count_q    <= 32'h0;
      irq_pend_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      // A bus write to CTRL overrides the one-shot En clear in INT.
      if (wr_ctrl) begin
        ctrl_q <= ctrl_d;
      end else if (state_q == ST_INT && !mode_nz) begin
        ctrl_q[CTRL_EN] <= 1'b0;
      end

      if (wr_preset) preset_q <= preset_d;

      if (state_q == ST_CNT && en && count_q == 32'h0) begin
        irq_pend_q <= 1'b1;
      end else if (wr_ctrl || (state_q == ST_INT && mode_nz)) begin
        irq_pend_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: if (en) state_q <= ST_LOAD;
        ST_LOAD: begin
          count_q <= preset_q;
          state_q <= ST_CNT;
        end
        ST_CNT: begin
          if (!en) begin
            state_q <= ST_IDLE;
          end else if (count_q == 32'h0) begin
            state_q <= ST_INT;
          end else begin
            count_q <= count_q - 32'd1;
          end
        end
        ST_INT:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dev_timer.sv
// ============================================================================
// tb_dev_timer : directed and randomized checks of dev_timer vs timeline model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dev_timer;

  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_PRESET = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_RSVD   = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  byteen = 4'h0;
  logic [31:0] rdata;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  dev_timer #(.BASE(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .byteen(byteen), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; wdata = d; byteen = be;
    tick();
    byteen = 4'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Expected behaviour t edges after the enabling CTRL write, starting from
  // COUNT=0: load completes at t=2, then N+1 count values, then INT at t=N+3.
  // Auto-reload repeats every N+4 edges from t=2.
  function automatic logic [31:0] m_count(input int n, input logic m0, input int t);
    int r;
    if (t < 2) return 32'h0;
    r = t - 2;
    if (!m0) r = r % (n + 4);
    return (r <= n) ? 32'(n - r) : 32'h0;
  endfunction

  function automatic logic m_irq(input int n, input logic m0, input logic im, input int t);
    if (t < 2) return 1'b0;
    if (m0) return im && (t >= n + 3);
    return im && (((t - 2) % (n + 4)) == n + 1);
  endfunction

  function automatic logic [31:0] m_ctrl(input int n, input logic [1:0] mode,
                                         input logic im, input int t);
    logic en;
    en = !((mode == 2'b00) && (t >= n + 4));
    return {28'h0, im, mode, en};
  endfunction

  task automatic run_timeline(input string tag, input int n, input logic [1:0] mode,
                              input logic im, input int cycles);
    logic [31:0] v;
    logic        m0;
    m0 = (mode == 2'b00);
    for (int t = 1; t <= cycles; t++) begin
      tick();
      chk({tag, "_irq"}, {31'h0, irq}, {31'h0, m_irq(n, m0, im, t)});
      bus_rd(A_COUNT, v);
      chk({tag, "_count"}, v, m_count(n, m0, t));
      bus_rd(A_CTRL, v);
      chk({tag, "_ctrl"}, v, m_ctrl(n, mode, im, t));
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] exp_preset;
    logic [31:0] rnd;
    logic [31:0] mask;
    logic [3:0]  be;
    int          n;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] frozen;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    bus_rd(A_CTRL, v);   chk("rst_ctrl", v, 32'h0);
    bus_rd(A_PRESET, v); chk("rst_preset", v, 32'h0);
    bus_rd(A_COUNT, v);  chk("rst_count", v, 32'h0);
    bus_rd(A_RSVD, v);   chk("rst_rsvd", v, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);

    // One-shot: irq at write+8, holds, En cleared, CTRL write drops irq
    bus_wr(A_PRESET, 32'd5, 4'hF);
    bus_wr(A_CTRL, 32'h9, 4'hF);
    run_timeline("oneshot", 5, 2'b00, 1'b1, 12);
    bus_rd(A_CTRL, v); chk("oneshot_ctrl_after", v, 32'h8);
    bus_wr(A_CTRL, 32'h0, 4'hF);
    chk("oneshot_irq_drop", {31'h0, irq}, 32'h0);

    // Auto-reload mode 1: pulses at write+6, then every 7
    do_reset();
    bus_wr(A_PRESET, 32'd3, 4'hF);
    bus_wr(A_CTRL, 32'hB, 4'hF);
    run_timeline("reload", 3, 2'b01, 1'b1, 24);

    // Byte lanes, COUNT write ignored, reserved and out-of-window accesses
    do_reset();
    bus_wr(A_PRESET, 32'hAABB_CCDD, 4'b0101);
    bus_rd(A_PRESET, v); chk("lane_0101", v, 32'h00BB_00DD);
    bus_wr(A_COUNT, 32'h1234_5678, 4'hF);
    bus_rd(A_COUNT, v); chk("count_wr_ignored", v, 32'h0);
    bus_wr(A_RSVD, 32'hFFFF_FFFF, 4'hF);
    bus_rd(A_RSVD, v); chk("rsvd_read", v, 32'h0);
    bus_wr(A_CTRL, 32'hFFFF_FFF0, 4'hF);
    bus_rd(A_CTRL, v); chk("ctrl_unstored_bits", v, 32'h0);
    bus_wr(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    bus_rd(BASE + 32'h10, v); chk("outwin_rdata", v, 32'h0);
    bus_rd(A_PRESET, v); chk("outwin_preset", v, 32'h00BB_00DD);
    bus_rd(A_CTRL, v); chk("outwin_ctrl", v, 32'h0);
    bus_rd(A_PRESET + 32'h3, v); chk("addr_lsb_ignored", v, 32'h00BB_00DD);

    // Random byte-lane writes to PRESET
    exp_preset = 32'h00BB_00DD;
    for (int k = 0; k < 20; k++) begin
      rnd  = $urandom;
      be   = 4'($urandom_range(0, 15));
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      exp_preset = (exp_preset & ~mask) | (rnd & mask);
      bus_wr(A_PRESET, rnd, be);
      bus_rd(A_PRESET, v); chk("rand_lane", v, exp_preset);
    end

    // Full-range PRESET: counts down from all ones without wrapping
    do_reset();
    bus_wr(A_PRESET, 32'hFFFF_FFFF, 4'hF);
    bus_wr(A_CTRL, 32'h1, 4'hF);
    tick();
    for (int t = 2; t <= 5; t++) begin
      tick();
      bus_rd(A_COUNT, v); chk("max_preset", v, 32'hFFFF_FFFF - 32'(t - 2));
    end

    // Disable mid-count: COUNT freezes, irq stays low
    do_reset();
    bus_wr(A_PRESET, 32'd10, 4'hF);
    bus_wr(A_CTRL, 32'h9, 4'hF);
    for (int t = 1; t <= 4; t++) tick();
    bus_wr(A_CTRL, 32'h8, 4'hF);
    bus_rd(A_COUNT, v); chk("disable_count", v, 32'd7);
    frozen = v;
    for (int t = 0; t < 15; t++) begin
      tick();
      bus_rd(A_COUNT, v); chk("disable_frozen", v, frozen);
      chk("disable_irq", {31'h0, irq}, 32'h0);
    end

    // Reset mid-count with a bus write in the same cycle
    bus_wr(A_CTRL, 32'h9, 4'hF);
    for (int t = 1; t <= 5; t++) tick();
    addr = A_PRESET; wdata = 32'hDEAD_BEEF; byteen = 4'hF; reset = 1'b1;
    tick();
    reset = 1'b0; byteen = 4'h0;
    bus_rd(A_CTRL, v);   chk("midrst_ctrl", v, 32'h0);
    bus_rd(A_PRESET, v); chk("midrst_preset", v, 32'h0);
    bus_rd(A_COUNT, v);  chk("midrst_count", v, 32'h0);
    chk("midrst_irq", {31'h0, irq}, 32'h0);
    tick(); tick();
    bus_rd(A_COUNT, v);  chk("midrst_idle", v, 32'h0);

    // Randomized timer trials against the timeline model
    for (int k = 0; k < 30; k++) begin
      n    = int'($urandom_range(0, 10));
      mode = 2'($urandom_range(0, 3));
      im   = 1'($urandom_range(0, 1));
      do_reset();
      bus_wr(A_PRESET, 32'(n), 4'hF);
      bus_wr(A_CTRL, {28'h0, im, mode, 1'b1}, 4'hF);
      run_timeline("rand", n, mode, im, 2 * (n + 4) + 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
